button_press_decoder: RTL

Classifies each debounced button press into short, long or double press, and optionally auto-repeats while a long press is held. Sits directly downstream of the button debouncer: it consumes the debounced level (`stable_out` of `debounce`) and emits registered single-cycle event pulses to the application FSMs. Performs its own edge detection, because press duration must be measured on the level.

---
 rtl/button_press_decoder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/button_press_decoder.sv
// Classifies debounced button presses into short, long and double press pulses.
// Optional auto-repeat while long-held is compiled in with `define BUTTON_REPEAT_EN.
module button_press_decoder #(
    parameter int unsigned LONG_CYC   = 50_000_000,
    parameter int unsigned DBL_CYC    = 15_000_000,
    parameter int unsigned REPEAT_CYC = 10_000_000,
    parameter int unsigned CNT_W      = 26
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic btn_level,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic repeat_press
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PRESS1 = 3'd1;
    localparam logic [2:0] ST_WAIT2  = 3'd2;
    localparam logic [2:0] ST_PRESS2 = 3'd3;
    localparam logic [2:0] ST_LONG   = 3'd4;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CYC - 1);

    localparam bit CFG_OK =
        (LONG_CYC >= 2) && (64'(LONG_CYC) < (64'd1 << CNT_W)) &&
        (DBL_CYC >= 2) && (64'(DBL_CYC) < (64'd1 << CNT_W)) &&
        (REPEAT_CYC >= 2) && (64'(REPEAT_CYC) < (64'd1 << CNT_W));

    if (!CFG_OK) begin : g_bad_cfg
        $error("button_press_decoder: *_CYC must be >= 2 and < 2**CNT_W");
    end

    logic             s0_q, s1_q;
    logic             rise, fall;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             double_q, double_d;

`ifdef BUTTON_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);
    logic             repeat_q, repeat_d;
`endif

    assign rise = s0_q & ~s1_q;
    assign fall = ~s0_q & s1_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        short_d  = 1'b0;
        long_d   = 1'b0;
        double_d = 1'b0;
`ifdef BUTTON_REPEAT_EN
        repeat_d = 1'b0;
`endif
        // Edge tests come first in each state so a coincident edge beats the timeout.
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (rise) state_d = ST_PRESS1;
            end
            ST_PRESS1: begin
                if (fall) begin
                    state_d = ST_WAIT2;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = ST_LONG;
                    long_d  = 1'b1;
                end
            end
            ST_WAIT2: begin
                if (rise) begin
                    state_d  = ST_PRESS2;
                    double_d = 1'b1;
                end else if (cnt_q == DBL_LAST) begin
                    state_d = ST_IDLE;
                    short_d = 1'b1;
                end
            end
            ST_PRESS2: begin
                cnt_d = '0;
                if (fall) state_d = ST_IDLE;
            end
            ST_LONG: begin
`ifdef BUTTON_REPEAT_EN
                if (fall) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == REPEAT_LAST) begin
                    repeat_d = 1'b1;
                    cnt_d    = '0;
                end
`else
                cnt_d = '0;
                if (fall) state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // Reset is active-high despite its name; loading both sync stages with the
    // live level suppresses a phantom edge for a button held through reset.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge sys_clk) begin
        if (sys_rst_n) begin
            s0_q     <= btn_level;
            s1_q     <= btn_level;
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
        end else begin
            s0_q     <= btn_level;
            s1_q     <= s0_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            short_q  <= short_d;
            long_q   <= long_d;
            double_q <= double_d;
        end
    end

`ifdef BUTTON_REPEAT_EN
    always_ff @(posedge sys_clk) begin
        if (sys_rst_n) repeat_q <= 1'b0;
        else           repeat_q <= repeat_d;
    end
    assign repeat_press = repeat_q;
`else
    assign repeat_press = 1'b0;
`endif

    assign short_press  = short_q;
    assign long_press   = long_q;
    assign double_press = double_q;

endmodule
